// File: rtl/elm_acc_pkg.sv
// Shared definitions for the ELM accumulator bank: FSM state encoding,
// saturation bounds and packed-bus slice helper.
package elm_acc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Saturation bounds for a given signed accumulator width (w <= 63).
  function automatic logic signed [63:0] acc_max_f(input int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] acc_min_f(input int w);
    return -(64'sd1 <<< (w - 1));
  endfunction

  // Bounds for the default 32-bit accumulator.
  localparam int                 ACC_W_DEF = 32;
  localparam logic signed [63:0] ACC_MAX   = acc_max_f(ACC_W_DEF);
  localparam logic signed [63:0] ACC_MIN   = acc_min_f(ACC_W_DEF);

  // Low bit index of channel k in a packed bus of w-bit lanes.
  function automatic int slice_lo(input int k, input int w);
    return k * w;
  endfunction

endpackage

// File: rtl/elm_sat_acc_ch.sv
// One accumulator channel: sign-extends the term, adds at ACC_W+1 bits,
// clamps to the signed ACC_W range and keeps a sticky saturation flag.
module elm_sat_acc_ch
  import elm_acc_pkg::*;
#(
  parameter int ACC_W = 32,
  parameter int IN_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             add_en,
  input  logic [IN_W-1:0]  term,
  output logic [ACC_W-1:0] acc,
  output logic             sat
);

  localparam logic signed [63:0]    MAX64   = acc_max_f(ACC_W);
  localparam logic signed [63:0]    MIN64   = acc_min_f(ACC_W);
  localparam logic signed [ACC_W:0] SUM_MAX = MAX64[ACC_W:0];
  localparam logic signed [ACC_W:0] SUM_MIN = MIN64[ACC_W:0];

  logic [ACC_W-1:0]        acc_q, acc_d;
  logic                    sat_q, sat_d;
  logic signed [ACC_W:0]   term_ext_s;
  logic signed [ACC_W:0]   acc_ext_s;
  logic signed [ACC_W:0]   sum_s;

  // Next-state: clear wins, otherwise add-with-clamp on an accepted term.
  always_comb begin
    term_ext_s = (ACC_W + 1)'($signed(term));
    acc_ext_s  = (ACC_W + 1)'($signed(acc_q));
    sum_s      = acc_ext_s + term_ext_s;
    acc_d      = acc_q;
    sat_d      = sat_q;
    if (clear) begin
      acc_d = '0;
      sat_d = 1'b0;
    end else if (add_en) begin
      if (sum_s > SUM_MAX) begin
        acc_d = SUM_MAX[ACC_W-1:0];
        sat_d = 1'b1;
      end else if (sum_s < SUM_MIN) begin
        acc_d = SUM_MIN[ACC_W-1:0];
        sat_d = 1'b1;
      end else begin
        acc_d = sum_s[ACC_W-1:0];
      end
    end else begin
      acc_d = acc_q;
      sat_d = sat_q;
    end
  end

  // Channel state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      sat_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      sat_q <= sat_d;
    end
  end

  assign acc = acc_q;
  assign sat = sat_q;

endmodule

// File: rtl/elm_acc_bank.sv
// N_CH-channel saturating accumulator bank: counts a programmed number of
// terms in ACCUM, then presents the result through a valid/ready handshake.
module elm_acc_bank
  import elm_acc_pkg::*;
#(
  parameter int ACC_W = 32,
  parameter int IN_W  = 16,
  parameter int N_CH  = 4,
  parameter int LEN_W = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  start,
  input  logic [LEN_W-1:0]      len,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [N_CH*IN_W-1:0]  in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [N_CH*ACC_W-1:0] out_data,
  output logic [N_CH-1:0]       sat,
  output logic                  busy
);

  state_e           state_q, state_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             accept_s;
  logic             ch_clear_s;
  logic             last_s;

  // Handshake outputs decode only the state register.
  assign in_ready  = (state_q == ST_ACCUM);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q == ST_ACCUM) || (state_q == ST_DONE);

  assign accept_s   = in_valid && (state_q == ST_ACCUM);
  assign ch_clear_s = clr || ((state_q == ST_IDLE) && start);
  assign last_s     = (cnt_q == (len_q - LEN_W'(1)));

  // FSM, term counter and length register next-state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    if (clr) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      len_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            cnt_d = '0;
            len_d = len;
            if (len != '0) begin
              state_d = ST_ACCUM;
            end else begin
              state_d = ST_DONE;
            end
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_ACCUM: begin
          if (accept_s) begin
            cnt_d = cnt_q + LEN_W'(1);
            if (last_s) begin
              state_d = ST_DONE;
            end else begin
              state_d = ST_ACCUM;
            end
          end else begin
            state_d = ST_ACCUM;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_DONE;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          len_d   = '0;
        end
      endcase
    end
  end

  // Control registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
    end
  end

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    elm_sat_acc_ch #(
      .ACC_W (ACC_W),
      .IN_W  (IN_W)
    ) u_ch (
      .clk    (clk),
      .rst    (rst),
      .clear  (ch_clear_s),
      .add_en (accept_s),
      .term   (in_data[slice_lo(k, IN_W) +: IN_W]),
      .acc    (out_data[slice_lo(k, ACC_W) +: ACC_W]),
      .sat    (sat[k])
    );
  end

endmodule

// File: tb/tb_elm_acc_bank.sv
// Directed table-driven bench for elm_acc_bank (ACC_W=20, IN_W=16, N_CH=4).
module tb_elm_acc_bank;

  localparam int ACC_W = 20;
  localparam int IN_W  = 16;
  localparam int N_CH  = 4;
  localparam int LEN_W = 10;

  logic                  clk = 1'b0;
  logic                  rst, clr, start, in_valid, out_ready;
  logic [LEN_W-1:0]      len;
  logic [N_CH*IN_W-1:0]  in_data;
  logic                  in_ready, out_valid, busy;
  logic [N_CH*ACC_W-1:0] out_data;
  logic [N_CH-1:0]       sat;

  int checks = 0;
  int errors = 0;

  elm_acc_bank #(.ACC_W(ACC_W), .IN_W(IN_W), .N_CH(N_CH), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .clr(clr), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .sat(sat), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic             rst, clr, start;
    logic [LEN_W-1:0] len;
    logic             iv;
    logic [63:0]      data;
    logic             ordy;
    logic             e_ir, e_ov, e_busy;
    logic [79:0]      e_data;
    logic [3:0]       e_sat;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [63:0] pin(input int a, input int b, input int c, input int d);
    return {16'(d), 16'(c), 16'(b), 16'(a)};
  endfunction

  function automatic logic [79:0] pout(input int a, input int b, input int c, input int d);
    return {20'(d), 20'(c), 20'(b), 20'(a)};
  endfunction

  function automatic vec_t mk(input logic r, input logic c, input logic s, input int l,
                              input logic iv, input logic [63:0] d, input logic o,
                              input logic ir, input logic ov, input logic bz,
                              input logic [79:0] ed, input logic [3:0] es);
    vec_t v;
    v.rst = r; v.clr = c; v.start = s; v.len = LEN_W'(l); v.iv = iv; v.data = d; v.ordy = o;
    v.e_ir = ir; v.e_ov = ov; v.e_busy = bz; v.e_data = ed; v.e_sat = es;
    return v;
  endfunction

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic drive(input logic r, input logic c, input logic s, input int l,
                       input logic iv, input logic [63:0] d, input logic o);
    @(negedge clk);
    rst = r; clr = c; start = s; len = LEN_W'(l); in_valid = iv; in_data = d; out_ready = o;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ctl(input string name, input logic ir, input logic ov, input logic bz);
    chk({name, ".in_ready"}, 128'(in_ready), 128'(ir));
    chk({name, ".out_valid"}, 128'(out_valid), 128'(ov));
    chk({name, ".busy"}, 128'(busy), 128'(bz));
  endtask

  initial begin
    logic [79:0] hold;
    rst = 1'b1; clr = 1'b0; start = 1'b0; len = '0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

    // Reset, basic sum (start in ACCUM and stray in_data ignored).
    vecs.push_back(mk(1,0,0,0, 0,pin(0,0,0,0),0,           0,0,0, pout(0,0,0,0),4'b0000));
    vecs.push_back(mk(0,0,1,3, 1,pin(99,99,99,99),0,       1,0,1, pout(0,0,0,0),4'b0000));
    vecs.push_back(mk(0,0,0,0, 1,pin(10,100,0,-1),0,       1,0,1, pout(10,100,0,-1),4'b0000));
    vecs.push_back(mk(0,0,1,7, 1,pin(-3,200,0,-1),0,       1,0,1, pout(7,300,0,-2),4'b0000));
    vecs.push_back(mk(0,0,0,0, 1,pin(7,300,0,-1),0,        0,1,1, pout(14,600,0,-3),4'b0000));
    vecs.push_back(mk(0,0,0,0, 1,pin(5,5,5,5),1,           0,0,0, pout(14,600,0,-3),4'b0000));
    // Reset mid-ACCUM.
    vecs.push_back(mk(0,0,1,5, 0,pin(0,0,0,0),0,           1,0,1, pout(0,0,0,0),4'b0000));
    vecs.push_back(mk(0,0,0,0, 1,pin(1,2,3,4),0,           1,0,1, pout(1,2,3,4),4'b0000));
    vecs.push_back(mk(0,0,0,0, 1,pin(1,2,3,4),0,           1,0,1, pout(2,4,6,8),4'b0000));
    vecs.push_back(mk(1,0,0,0, 1,pin(1,2,3,4),0,           0,0,0, pout(0,0,0,0),4'b0000));
    // len=0 goes straight to DONE with zero result.
    vecs.push_back(mk(0,0,1,0, 1,pin(9,9,9,9),0,           0,1,1, pout(0,0,0,0),4'b0000));
    vecs.push_back(mk(0,0,1,4, 1,pin(9,9,9,9),0,           0,1,1, pout(0,0,0,0),4'b0000));
    vecs.push_back(mk(0,0,0,0, 0,pin(0,0,0,0),1,           0,0,0, pout(0,0,0,0),4'b0000));
    // clr in DONE drops the result; start in the clr cycle ignored.
    vecs.push_back(mk(0,0,1,1, 0,pin(0,0,0,0),0,           1,0,1, pout(0,0,0,0),4'b0000));
    vecs.push_back(mk(0,0,0,0, 1,pin(5,6,7,8),0,           0,1,1, pout(5,6,7,8),4'b0000));
    vecs.push_back(mk(0,0,0,0, 0,pin(0,0,0,0),0,           0,1,1, pout(5,6,7,8),4'b0000));
    vecs.push_back(mk(0,1,1,2, 0,pin(0,0,0,0),0,           0,0,0, pout(0,0,0,0),4'b0000));
    vecs.push_back(mk(0,0,0,0, 0,pin(0,0,0,0),0,           0,0,0, pout(0,0,0,0),4'b0000));

    foreach (vecs[i]) begin
      string n;
      n = $sformatf("vec%0d", i);
      drive(vecs[i].rst, vecs[i].clr, vecs[i].start, int'(vecs[i].len),
            vecs[i].iv, vecs[i].data, vecs[i].ordy);
      chk_ctl(n, vecs[i].e_ir, vecs[i].e_ov, vecs[i].e_busy);
      chk({n, ".out_data"}, 128'(out_data), 128'(vecs[i].e_data));
      chk({n, ".sat"}, 128'(sat), 128'(vecs[i].e_sat));
    end

    // Input gaps 1,0,0,1,1 then 4 cycles of backpressure.
    drive(0,0,1,3, 0,pin(0,0,0,0),0);
    drive(0,0,0,0, 1,pin(5,-7,0,1),0);
    drive(0,0,0,0, 0,pin(1000,1000,1000,1000),0);
    drive(0,0,0,0, 0,pin(1000,1000,1000,1000),0);
    drive(0,0,0,0, 1,pin(-2,3,0,1),0);
    chk_ctl("gap.mid", 1'b1, 1'b0, 1'b1);
    drive(0,0,0,0, 1,pin(4,1,0,1),0);
    hold = pout(7,-3,0,3);
    for (int c = 0; c < 4; c++) begin
      chk_ctl($sformatf("bp%0d", c), 1'b0, 1'b1, 1'b1);
      chk($sformatf("bp%0d.out_data", c), 128'(out_data), 128'(hold));
      if (c < 3) drive(0,0,0,0, 1,pin(50,50,50,50),0);
    end
    drive(0,0,0,0, 0,pin(0,0,0,0),1);
    chk_ctl("bp.release", 1'b0, 1'b0, 1'b0);

    // Saturation: 20 terms drive ch1 to +max and ch2 to -min.
    drive(0,0,1,20, 0,pin(0,0,0,0),0);
    for (int t = 0; t < 20; t++) drive(0,0,0,0, 1,pin(1,32767,-32768,-1),0);
    chk_ctl("sat", 1'b0, 1'b1, 1'b1);
    chk("sat.out_data", 128'(out_data), 128'(pout(20,524287,-524288,-20)));
    chk("sat.flags", 128'(sat), 128'(4'b0110));
    drive(0,0,0,0, 0,pin(0,0,0,0),1);
    chk("sat.sticky_idle", 128'(sat), 128'(4'b0110));
    drive(0,0,1,1, 0,pin(0,0,0,0),0);
    chk("sat.cleared_on_start", 128'(sat), 128'(4'b0000));
    chk("sat.acc_cleared", 128'(out_data), 128'(pout(0,0,0,0)));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/elm_acc_bank.md
Name: elm_acc_bank

Overview:
Multi-channel signed accumulator bank for the ELM hidden/output-layer datapath. It generalises the single-width load/clear accumulator register to N_CH parallel channels. Each channel accumulates a programmed number of sign-extended terms with per-channel saturation. Results are presented through a valid/ready handshake to the downstream activation/storage stage.

Parameters:
ACC_W, 32, accumulator width per channel (signed two's complement)
IN_W, 16, input term width per channel (signed), IN_W <= ACC_W
N_CH, 4, number of parallel channels
LEN_W, 10, width of term-count register (max terms 2^LEN_W-1)

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous reset, active-high
clr  input  1  synchronous clear; aborts any operation; priority below rst
start  input  1  begin a new accumulation; sampled in IDLE only
len  input  LEN_W  number of terms to accumulate, sampled with start
in_valid  input  1  input terms valid
in_ready  output  1  bank accepts terms (high only in ACCUM)
in_data  input  N_CH*IN_W  packed terms, channel k at [k*IN_W +: IN_W]
out_valid  output  1  result available (high only in DONE)
out_ready  input  1  downstream accepts result
out_data  output  N_CH*ACC_W  packed accumulators, channel k at [k*ACC_W +: ACC_W]
sat  output  N_CH  sticky per-channel saturation flag for current result
busy  output  1  high in ACCUM or DONE

Behaviour:
- Reset (rst=1): state=IDLE; all accumulators=0; sat=0; term counter=0; len register=0; in_ready=0, out_valid=0, busy=0.
- Priority per cycle: rst > clr > start/handshake.
- clr=1 (rst=0): same effect as reset. A DONE result is dropped without a handshake.
- FSM states: IDLE, ACCUM, DONE.
- IDLE, start=1, len!=0: accumulators=0, sat=0, counter=0, len latched; next state ACCUM.
- IDLE, start=1, len==0: accumulators=0, sat=0; next state DONE (zero result).
- start outside IDLE is ignored.
- ACCUM: in_ready=1. A term is accepted on in_valid && in_ready.
- On each accepted term, every channel computes acc + sign_extend(term). The sum is computed at ACC_W+1 bits.
- Saturation: if the sum exceeds 2^(ACC_W-1)-1, clamp to that value; if it is below -2^(ACC_W-1), clamp to that value. Either clamp sets the channel's sat bit (sticky until next start/clr/rst).
- Counter increments on each accepted term. When the accepted term has counter==len_reg-1, the next state is DONE. The final term is included in the result.
- Latency: the result is visible on out_data with out_valid=1 in the cycle after the last term is accepted.
- ACCUM with in_valid=0: hold all state, no timeout.
- DONE: out_valid=1, in_ready=0, and out_data/sat are stable.
- DONE, out_valid && out_ready: next state IDLE. Accumulators keep their value until the next start or clr.
- out_data always drives the accumulator registers directly. Its contents are meaningful only while out_valid=1.
- in_data is ignored unless in_valid && in_ready.
- No combinational path from in_valid or out_ready to in_ready or out_valid. All outputs are registered or decoded from the state register only.

Decomposition:
- Shared package elm_acc_pkg holds:
  - state enum (IDLE/ACCUM/DONE)
  - localparams for ACC_MAX/ACC_MIN derived from ACC_W
  - a slice-index helper for packed channel buses.
- One sub-module, elm_sat_acc_ch, instantiated N_CH times. It contains one channel's register, sign-extend, (ACC_W+1)-bit add, clamp and sticky sat bit. Its controls are clear, add_en and a term input.
- The top level holds the FSM, the counter and the handshake.

Test Plan:
- Reset mid-ACCUM: start len=5, accept 2 terms, assert rst -> next cycle state IDLE, out_data all 0, sat=0, in_ready=0, out_valid=0.
- Basic sum, N_CH=4: start len=3; ch0 terms 10, -3, 7 and ch3 terms -1, -1, -1 -> one cycle after the 3rd accepted term, out_valid=1, ch0=14, ch3=-3, sat=0000.
- Input gaps plus downstream backpressure: in_valid toggled 1,0,0,1,1 with len=3; out_ready held 0 for 4 cycles -> exactly 3 terms summed, out_valid held high with out_data stable all 4 cycles, IDLE the cycle after out_ready=1.
- Saturation, ACC_W=20, IN_W=16: ch1 fed 32767 ×20 -> ch1=524287 and sat[1]=1. ch2 fed -32768 ×20 -> ch2=-524288 and sat[2]=1. Other channels have sat=0.
- len=0 start -> DONE on the next cycle, out_data all 0, in_ready never asserted.
- clr in DONE with out_ready=0 -> IDLE next cycle, out_valid=0, accumulators 0. A start in that same clr cycle is ignored.
